// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode boundary types: IF_ID pipeline register layout and the NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fetched_inst;
    } IF_ID;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Generic synchronous FIFO with flush; head is visible combinationally while not empty.
// Latency: a push at edge M is readable as head after edge M (pop no earlier than edge M+1).
// Backpressure: caller must not push when full unless popping in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push+pop at full is allowed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer/occupancy; flush discards everything including this cycle's push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, issues in-order imem requests, buffers responses, feeds IF_ID.
// Latency: response pushed at edge M reaches if_id_reg at edge M+1 earliest; NOP when nothing ready.
// Backpressure: stall holds if_id_reg; requests throttled so outstanding+buffered <= FIFO_DEPTH.
// Optional: define FETCH_PERF_COUNTERS_EN to add perf_fetch_count / perf_bubble_count outputs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output IF_ID        if_id_reg
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_bubble_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [0:0]    state_q, state_d;
    IF_ID          if_id_q, if_id_d;

    logic          accept, drop, resp_keep, data_pop;
    logic          deliver, bubble;
    logic [31:0]   tag_head;
    logic          tag_full, tag_empty;
    logic [CW-1:0] tag_cnt;
    logic [63:0]   data_head;
    logic          data_full, data_empty;
    logic [CW-1:0] data_cnt;

    // Credit: never have more requests in flight plus buffered than the FIFO can hold.
    assign imem_req_valid = !redirect_valid &&
        (({1'b0, outstanding_q} + {1'b0, data_cnt}) < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // In FLUSH every response belongs to a pre-redirect request and is dropped.
    assign drop      = (state_q == ST_FLUSH);
    assign resp_keep = imem_resp_valid && !drop && !redirect_valid;
    assign data_pop  = !redirect_valid && !stall && !data_empty;

    fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push     (accept),
        .push_dat (pc_q),
        .pop      (resp_keep && !tag_empty),
        .head_dat (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_cnt)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push     (resp_keep),
        .push_dat ({tag_head, imem_resp_data}),
        .pop      (data_pop),
        .head_dat (data_head),
        .full     (data_full),
        .empty    (data_empty),
        .count    (data_cnt)
    );

    // PC, in-flight accounting and flush state.
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (redirect_valid) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            // Everything still in flight after this cycle is stale.
            outstanding_d = outstanding_q - CW'(imem_resp_valid);
            discard_d     = outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            outstanding_d = outstanding_q + CW'(accept) - CW'(imem_resp_valid);
            discard_d     = discard_q - CW'(imem_resp_valid && drop);
        end
        state_d = (discard_d != '0) ? ST_FLUSH : ST_RUN;
    end

    // IF_ID output: deliver head, emit NOP bubble when empty or redirecting, hold on stall.
    always_comb begin
        if_id_d = if_id_q;
        deliver = 1'b0;
        bubble  = 1'b0;
        if (redirect_valid) begin
            if_id_d.fetched_inst = INST_NOP;
            bubble               = !stall;
        end else if (!stall) begin
            if (!data_empty) begin
                if_id_d = IF_ID'(data_head);
                deliver = 1'b1;
            end else begin
                if_id_d.fetched_inst = INST_NOP;
                bubble               = 1'b1;
            end
        end
    end

    // Fetch stage state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            state_q       <= ST_RUN;
            if_id_q       <= '{pc: 32'h0, fetched_inst: INST_NOP};
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            state_q       <= state_d;
            if_id_q       <= if_id_d;
        end
    end

    assign if_id_reg = if_id_q;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Delivered-instruction and bubble counters, free-running with natural wrap.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + 32'(deliver);
        bubble_cnt_d = bubble_cnt_q + 32'(bubble);
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_count  = fetch_cnt_q;
    assign perf_bubble_count = bubble_cnt_q;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, tag_full, tag_cnt, data_full, redirect_pc[1:0]};
`else
    logic unused_sigs;
    assign unused_sigs = &{1'b0, tag_full, tag_cnt, data_full, redirect_pc[1:0],
                           deliver, bubble};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model.
// Memory answers each accepted address one cycle later (gated by rsp_en), data = {16'hC0DE, addr[15:0]}.
// Inputs change 2 time units after posedge, memory 3 units after; outputs checked after that.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    IF_ID        if_id_reg;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_bubble_count;
`endif

    int total = 0;
    int bad   = 0;
    bit rsp_en;

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_id_reg       (if_id_reg)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetch_count  (perf_fetch_count),
        .perf_bubble_count (perf_bubble_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory model: in-order queue of accepted addresses.
    initial begin : mem_model
        logic [31:0] mq[$];
        bit          acc;
        bit          rsp;
        logic [31:0] acc_addr;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            acc      = reset_n && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            rsp      = imem_resp_valid;
            @(posedge clk);
            #3;
            if (!reset_n) begin
                mq.delete();
            end else begin
                if (rsp && mq.size() > 0) void'(mq.pop_front());
                if (acc) mq.push_back(acc_addr);
            end
            imem_resp_valid = rsp_en && reset_n && (mq.size() > 0);
            imem_resp_data  = (mq.size() > 0) ? inst_of(mq[0]) : 32'h0;
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".pc"}, if_id_reg.pc, pc);
        chk({tag, ".inst"}, if_id_reg.fetched_inst, inst);
    endtask

    initial begin : stim
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        cyc();
        cyc();

        // Reset state
        chk_out("reset", 32'h0, INST_NOP);
        chk("reset.req_valid", 32'(imem_req_valid), 32'd1);
        chk("reset.addr", imem_req_addr, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("reset.perf_fetch", perf_fetch_count, 32'h0);
        chk("reset.perf_bubble", perf_bubble_count, 32'h0);
`endif
        reset_n = 1'b1;

        // Streaming fetch, one instruction per cycle after fill
        cyc();                                            // E1
        chk("stream.addr1", imem_req_addr, 32'h4);
        cyc();                                            // E2
        chk_out("stream.fill", 32'h0, INST_NOP);
        chk("stream.addr2", imem_req_addr, 32'h8);
        for (int i = 0; i < 3; i++) begin                 // E3..E5
            cyc();
            chk_out("stream.out", 32'(4 * i), inst_of(32'(4 * i)));
        end

        // Stall 3 cycles: output held, credit limits requests
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin                 // E6..E8
            cyc();
            chk_out("stall.hold", 32'h8, inst_of(32'h8));
        end
        chk("stall.req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall.addr", imem_req_addr, 32'd28);
        stall = 1'b0;
        for (int i = 0; i < 6; i++) begin                 // E9..E14
            cyc();
            chk_out("release.out", 32'(12 + 4 * i), inst_of(32'(12 + 4 * i)));
        end

        // Redirect with two requests outstanding
        rsp_en = 1'b0;
        cyc();                                            // E15
        chk_out("pre_redir.out", 32'd36, inst_of(32'd36));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("redir.req_valid", 32'(imem_req_valid), 32'd0);
        cyc();                                            // E16
        chk_out("redir.out", 32'd36, INST_NOP);
        chk("redir.addr", imem_req_addr, 32'h100);
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        for (int i = 0; i < 3; i++) begin                 // E17..E19: stale drops + fill
            cyc();
            chk_out("redir.bubble", 32'd36, INST_NOP);
        end
        cyc();                                            // E20
        chk_out("redir.first", 32'h100, inst_of(32'h100));
        cyc();                                            // E21
        chk_out("redir.second", 32'h104, inst_of(32'h104));

        // Redirect and stall in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        stall          = 1'b1;
        cyc();                                            // E22
        chk_out("redir_stall.out", 32'h104, INST_NOP);
        chk("redir_stall.addr", imem_req_addr, 32'h200);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        chk("redir_stall.req_valid", 32'(imem_req_valid), 32'd1);
        cyc();                                            // E23
        chk_out("redir_stall.b1", 32'h104, INST_NOP);
        cyc();                                            // E24
        chk_out("redir_stall.b2", 32'h104, INST_NOP);
        cyc();                                            // E25
        chk_out("redir_stall.first", 32'h200, inst_of(32'h200));
        chk("redir_stall.pc", imem_req_addr, 32'h20C);

        // imem_req_ready low for 5 cycles
        imem_req_ready = 1'b0;
        cyc();                                            // E26
        chk_out("noready.drain1", 32'h204, inst_of(32'h204));
        chk("noready.addr1", imem_req_addr, 32'h20C);
        cyc();                                            // E27
        chk_out("noready.drain2", 32'h208, inst_of(32'h208));
        for (int i = 0; i < 3; i++) begin                 // E28..E30
            cyc();
            chk_out("noready.bubble", 32'h208, INST_NOP);
            chk("noready.addr", imem_req_addr, 32'h20C);
        end
        imem_req_ready = 1'b1;

        // Reset mid-stream with responses in flight
        cyc();                                            // E31
        cyc();                                            // E32
        reset_n = 1'b0;
        #1;
        chk_out("midreset", 32'h0, INST_NOP);
        chk("midreset.addr", imem_req_addr, 32'h0);
        chk("midreset.req_valid", 32'(imem_req_valid), 32'd1);
        cyc();                                            // E33
        reset_n = 1'b1;
        cyc();                                            // E34
        chk("resume.addr", imem_req_addr, 32'h4);
        cyc();                                            // E35
        chk_out("resume.fill", 32'h0, INST_NOP);
        cyc();                                            // E36
        chk_out("resume.first", 32'h0, inst_of(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
